alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches the winning
// operation, executes for one cycle and holds the registered result until it is consumed.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_q;
  logic   id_p0;
  logic   win;
  logic   grant;

  // Winner index; with one requester valid it wins regardless of the pointer.
  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO)
      win = ~req_valid[0];
    else if (&req_valid)
      win = ~last_q;
    else
      win = req_valid[1];
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = win ? 2'b10 : 2'b01;
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      id_p0     <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= '0;
      resp_data <= '0;
      resp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Stage p0: latch the granted request; the ALU only ever sees these registers.
      if (grant) begin
        last_q <= win;
        id_p0  <= win;
        alu_A  <= win ? req1_a  : req0_a;
        alu_B  <= win ? req1_b  : req0_b;
        alu_op <= win ? req1_op : req0_op;
      end
      // Stage p1: capture the ALU result at the close of EXEC.
      if (state == EXEC) begin
        resp_data <= alu_out;
        resp_id   <= id_p0;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance checked through a response scoreboard,
// plus a fixed-priority instance checked on its grant pattern.
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_A, alu_B, alu_out, resp_data;
  logic        resp_valid, resp_ready, resp_id, busy;

  logic [1:0]  fp_req_valid, fp_req_ready;
  logic [3:0]  fp_alu_op;
  logic [31:0] fp_alu_A, fp_alu_B, fp_alu_out, fp_resp_data;
  logic        fp_resp_valid, fp_resp_id, fp_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        id;
    int          cyc;
  } exp_t;
  exp_t q[$];
  bit   shown = 1'b0;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADDU: return a + b;
      ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out    = alu_f(alu_op, alu_A, alu_B);
  assign fp_alu_out = alu_f(fp_alu_op, fp_alu_A, fp_alu_B);

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req0_op(ALU_ADDU), .req0_a(32'd1), .req0_b(32'd2),
    .req1_op(ALU_SUBU), .req1_a(32'd9), .req1_b(32'd4),
    .alu_A(fp_alu_A), .alu_B(fp_alu_B), .alu_op(fp_alu_op), .alu_out(fp_alu_out),
    .resp_valid(fp_resp_valid), .resp_ready(1'b1), .resp_data(fp_resp_data),
    .resp_id(fp_resp_id), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic id, input logic [31:0] data, input int gc);
    exp_t e;
    e.data = data;
    e.id   = id;
    e.cyc  = gc + 2;
    q.push_back(e);
  endtask

  task automatic wait_grant(input bit fp, input int maxc, output logic [1:0] g, output int gc);
    g  = 2'b00;
    gc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((fp ? fp_req_ready : req_ready) != 2'b00) begin
        g  = fp ? fp_req_ready : req_ready;
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no req_ready within %0d cycles", maxc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_id"}, {31'd0, resp_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_alu_A"}, alu_A, 32'd0);
    chk({tag, "_alu_B"}, alu_B, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
  endtask

  // Response monitor: latency on first presentation, content on consumption.
  always @(negedge clk) begin
    if (!rst_n) begin
      shown <= 1'b0;
    end else if (resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: data %h id %0d with nothing outstanding", resp_data, resp_id);
      end else begin
        if (!shown) begin
          chk("resp_latency", cyc, q[0].cyc);
          shown <= 1'b1;
        end
        if (resp_ready) begin
          chk("resp_data", resp_data, q[0].data);
          chk("resp_id", {31'd0, resp_id}, {31'd0, q[0].id});
          void'(q.pop_front());
          shown <= 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    int gc, prev;
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1; fp_req_valid = 2'b00;
    req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");

    // Round-robin contention straight out of reset: 0,1,0,1, three cycles apart.
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_op = ALU_SUBU; req0_a = 32'd10;  req0_b = 32'd3;
    req1_op = ALU_XOR;  req1_a = 32'hFF;  req1_b = 32'h0F;
    req_valid = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1'b0, 6, g, gc);
      chk("rr_grant", {30'd0, g}, (k % 2) ? 32'd2 : 32'd1);
      if (k > 0) chk("rr_spacing", gc - prev, 32'd3);
      prev = gc;
      expect_resp((k % 2) ? 1'b1 : 1'b0, (k % 2) ? 32'h0000_00F0 : 32'd7, gc);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Single ADDU 5+7 from requester 0.
    @(posedge clk); #1;
    req0_op = ALU_ADDU; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    wait_grant(1'b0, 4, g, gc);
    chk("single_grant", {30'd0, g}, 32'd1);
    expect_resp(1'b0, 32'd12, gc);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req0_a = 32'd99; req0_op = ALU_XOR;
    @(negedge clk);
    chk("exec_alu_A", alu_A, 32'd5);
    chk("exec_alu_B", alu_B, 32'd7);
    chk("exec_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADDU});
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_req_ready", {30'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_hold_alu_A", alu_A, 32'd5);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure: SLT -1 < 1 held for 10 cycles while requester 1 waits.
    @(posedge clk); #1;
    req0_op = ALU_SLT; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req_valid = 2'b01;
    wait_grant(1'b0, 4, g, gc);
    chk("bp_grant", {30'd0, g}, 32'd1);
    expect_resp(1'b0, 32'd1, gc);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 2'b10; req1_op = ALU_ADDU; req1_a = 32'd1; req1_b = 32'd2;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_data", resp_data, 32'd1);
      chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_grant(1'b0, 4, g, gc);
    chk("bp_next_grant", {30'd0, g}, 32'd2);
    expect_resp(1'b1, 32'd3, gc);

    // Undefined op code is forwarded unchanged.
    @(posedge clk); #1;
    req1_op = 4'hF; req1_a = 32'd1; req1_b = 32'd2;
    repeat (2) @(negedge clk);
    wait_grant(1'b0, 4, g, gc);
    chk("undef_grant", {30'd0, g}, 32'd2);
    expect_resp(1'b1, 32'hDEAD_BEEF, gc);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("undef_alu_op", {28'd0, alu_op}, 32'hF);
    repeat (2) @(negedge clk);

    // Reset during EXEC: operation discarded, pointer back to requester 0.
    @(posedge clk); #1;
    req0_op = ALU_ADDU; req0_a = 32'd1; req0_b = 32'd1; req_valid = 2'b01;
    wait_grant(1'b0, 4, g, gc);
    chk("rst_grant", {30'd0, g}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_op = ALU_ADDU; req0_a = 32'd2; req0_b = 32'd3;
    req1_op = ALU_ADDU; req1_a = 32'd4; req1_b = 32'd4;
    req_valid = 2'b11;
    wait_grant(1'b0, 4, g, gc);
    chk("post_rst_grant", {30'd0, g}, 32'd1);
    expect_resp(1'b0, 32'd5, gc);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Fixed priority: requester 1 starves until requester 0 drops.
    @(posedge clk); #1;
    fp_req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1'b1, 6, g, gc);
      chk("fp_grant_req0", {30'd0, g}, 32'd1);
    end
    prev = gc;
    @(posedge clk); #1;
    fp_req_valid = 2'b10;
    wait_grant(1'b1, 6, g, gc);
    chk("fp_grant_req1", {30'd0, g}, 32'd2);
    chk("fp_grant_req1_cycle", gc - prev, 32'd3);
    @(posedge clk); #1;
    fp_req_valid = 2'b00;
    repeat (4) @(negedge clk);

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
